// File: rtl/sm_color_sensor_emulator.sv
// sm_color_sensor_emulator
//
// Emulates a TCS3200-class colour sensor. The sensor control pins select a
// photodiode channel and an output scaling; cs_out is a 50 % square wave whose
// half-period is the programmed channel value times the scaling multiplier.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   S0, S1             scaling select (00 off, 01 x50, 10 x5, 11 x1), async pins
//   S2, S3             filter select (00 red, 01 blue, 10 clear, 11 green), async pins
//   OE                 output enable, active-low, async pin
//   cfg_we/sel/data    one-cycle write of a channel half-period (0 = dark)
//   cs_out             emulated sensor frequency output (registered)
//   cs_oe_n            synchronised OE, for pad tri-state control
//
// Optional build macro SM_CS_EMU_JITTER_EN: an 8-bit LFSR stretches each
// half-period by one cycle whenever its LSB is set, modelling edge jitter.
module sm_color_sensor_emulator #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    input  logic             S3,
    input  logic             OE,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             cs_out,
    output logic             cs_oe_n
);
    // x50 on a CNT_W value fits in CNT_W+6 bits (50 < 64).
    localparam int unsigned NW = CNT_W + 6;

    typedef enum logic [1:0] {StOff, StDark, StRun} state_e;

    // Pin synchronisers; select bits packed as {S0,S1,S2,S3}.
    logic [3:0] sel_meta_q, sel_sync_q, sel_prev_q;
    logic       oe_meta_q, oe_n_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_meta_q <= 4'b0000;
            sel_sync_q <= 4'b0000;
            sel_prev_q <= 4'b0000;
            oe_meta_q  <= 1'b1;
            oe_n_s     <= 1'b1;
        end else begin
            sel_meta_q <= {S0, S1, S2, S3};
            sel_sync_q <= sel_meta_q;
            sel_prev_q <= sel_sync_q;
            oe_meta_q  <= OE;
            oe_n_s     <= oe_meta_q;
        end
    end

    logic [1:0] scale, filt, ch;
    logic       sel_chg;

    assign scale   = sel_sync_q[3:2];
    assign filt    = sel_sync_q[1:0];
    assign sel_chg = (sel_sync_q != sel_prev_q);

    always_comb begin
        ch = 2'd0;
        unique case (filt)
            2'b00: ch = 2'd0;   // red
            2'b01: ch = 2'd2;   // blue
            2'b10: ch = 2'd3;   // clear
            2'b11: ch = 2'd1;   // green
        endcase
    end

    // Channel half-period registers.
    logic [CNT_W-1:0] hp_q [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hp_q[i] <= '0;
            end
        end else if (cfg_we) begin
            hp_q[cfg_sel] <= cfg_data;
        end
    end

    // Effective half-period via shift-add: x50 = 32+16+2, x5 = 4+1.
    logic [NW-1:0] hp_ext, n_now, n_toggle;

    assign hp_ext = NW'(hp_q[ch]);

    always_comb begin
        n_now = '0;
        unique case (scale)
            2'b01:   n_now = (hp_ext << 5) + (hp_ext << 4) + (hp_ext << 1);
            2'b10:   n_now = (hp_ext << 2) + hp_ext;
            2'b11:   n_now = hp_ext;
            default: n_now = '0;
        endcase
    end

    state_e        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d, n_q, n_d;
    logic          level_q, level_d;
    logic          cnt_hit;

    assign cnt_hit = (cnt_q == n_q - NW'(1));

`ifdef SM_CS_EMU_JITTER_EN
    logic [7:0] lfsr_q;
    logic       lfsr_adv;

    assign lfsr_adv = (scale != 2'b00) && (state_q == StRun) && !sel_chg && cnt_hit;

    // x^8+x^6+x^5+x^4+1, advanced once per toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else if (lfsr_adv) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign n_toggle = (n_now != '0) ? n_now + NW'(lfsr_q[0]) : '0;
`else
    assign n_toggle = n_now;
`endif

    // A select change outranks a coincident toggle: the counter restarts and
    // level holds, so the next edge is always a full new half-period away.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        level_d = level_q;
        if (scale == 2'b00) begin
            state_d = StOff;
            cnt_d   = '0;
            n_d     = '0;
            level_d = 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    cnt_d   = '0;
                    level_d = 1'b0;
                    n_d     = n_now;
                    state_d = (n_now == '0) ? StDark : StRun;
                end
                StDark: begin
                    cnt_d   = '0;
                    level_d = 1'b0;
                    if (n_now != '0) begin
                        n_d     = n_now;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (sel_chg) begin
                        cnt_d = '0;
                        n_d   = n_now;
                        if (n_now == '0) begin
                            state_d = StDark;
                            level_d = 1'b0;
                        end
                    end else if (cnt_hit) begin
                        cnt_d   = '0;
                        n_d     = n_toggle;
                        level_d = ~level_q;
                        if (n_now == '0) begin
                            state_d = StDark;
                            level_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StOff;
            cnt_q   <= '0;
            n_q     <= '0;
            level_q <= 1'b0;
            cs_out  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            level_q <= level_d;
            cs_out  <= level_d & ~oe_n_s;
        end
    end

    assign cs_oe_n = oe_n_s;

endmodule

// File: tb/tb_sm_color_sensor_emulator.sv
// Testbench for sm_color_sensor_emulator (default build, jitter disabled).
// A behavioural model tracks the remaining cycles of each half-period and is
// compared with the DUT outputs every cycle; directed sections pin the model
// with hand-computed latencies and periods.
module tb_sm_color_sensor_emulator;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             S0, S1, S2, S3, OE;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_data;
    logic             cs_out, cs_oe_n;

    int tests = 0;
    int fails = 0;

    sm_color_sensor_emulator #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .S0       (S0),
        .S1       (S1),
        .S2       (S2),
        .S3       (S3),
        .OE       (OE),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .cs_out   (cs_out),
        .cs_oe_n  (cs_oe_n)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0]       m_sel_m, m_sel_s, m_sel_p;
    logic             m_oe_m, m_oe_s;
    logic [CNT_W-1:0] m_hp [4];
    bit               m_off, m_dark, m_level;
    int               m_left;
    logic             m_cs, m_oe_n;

    function automatic int ch_of(input logic [1:0] f);
        case (f)
            2'b00:   return 0;
            2'b01:   return 2;
            2'b10:   return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int mult_of(input logic [1:0] s);
        case (s)
            2'b01:   return 50;
            2'b10:   return 5;
            2'b11:   return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_sel_m = 4'b0; m_sel_s = 4'b0; m_sel_p = 4'b0;
        m_oe_m = 1'b1; m_oe_s = 1'b1;
        for (int i = 0; i < 4; i++) m_hp[i] = '0;
        m_off = 1; m_dark = 0; m_level = 0; m_left = 0;
        m_cs = 1'b0; m_oe_n = 1'b1;
    endtask

    task automatic model_step();
        int nn;
        nn = int'(m_hp[ch_of(m_sel_s[1:0])]) * mult_of(m_sel_s[3:2]);
        if (m_sel_s[3:2] == 2'b00) begin
            m_off = 1; m_dark = 0; m_level = 0;
        end else if (m_off) begin
            m_off = 0; m_level = 0; m_dark = (nn == 0); m_left = nn;
        end else if (m_dark) begin
            if (nn != 0) begin m_dark = 0; m_left = nn; end
        end else if (m_sel_s != m_sel_p) begin
            m_left = nn;
            if (nn == 0) begin m_dark = 1; m_level = 0; end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_level = ~m_level;
                m_left  = nn;
                if (nn == 0) begin m_dark = 1; m_level = 0; end
            end
        end
        m_cs = m_level & ~m_oe_s;
        if (cfg_we) m_hp[cfg_sel] = cfg_data;
        m_sel_p = m_sel_s; m_sel_s = m_sel_m; m_sel_m = {S0, S1, S2, S3};
        m_oe_s = m_oe_m; m_oe_m = OE;
        m_oe_n = m_oe_s;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            tests++;
            if (cs_out !== m_cs) begin
                fails++;
                $display("FAIL cycle_cs_out @%0t: got %b, expected %b", $time, cs_out, m_cs);
            end
            tests++;
            if (cs_oe_n !== m_oe_n) begin
                fails++;
                $display("FAIL cycle_cs_oe_n @%0t: got %b, expected %b", $time, cs_oe_n, m_oe_n);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_pins(input logic [1:0] sc, input logic [1:0] fl, input logic oe);
        S0 = sc[1]; S1 = sc[0]; S2 = fl[1]; S3 = fl[0]; OE = oe;
    endtask

    task automatic write_hp(input logic [1:0] sel, input logic [CNT_W-1:0] data);
        cfg_sel = sel; cfg_data = data; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    // Cycles until cs_out changes; -1 and a failure on timeout.
    task automatic wait_change(input int budget, output int n);
        logic start;
        bit done;
        start = cs_out; n = 0; done = 0;
        while (!done) begin
            tick();
            n++;
            if (cs_out !== start) begin
                done = 1;
            end else if (n >= budget) begin
                done = 1; n = -1;
                tests++; fails++;
                $display("FAIL timeout waiting for cs_out change: got none, required within %0d", budget);
            end
        end
    endtask

    task automatic wait_level(input logic want, input int budget);
        int n;
        n = 0;
        while (cs_out !== want && n < budget) begin
            tick();
            n++;
        end
        if (cs_out !== want) begin
            tests++; fails++;
            $display("FAIL timeout waiting for cs_out=%b: got %b", want, cs_out);
        end
    endtask

    task automatic count_edges(input int cycles, output int edges);
        logic prev;
        edges = 0;
        for (int i = 0; i < cycles; i++) begin
            prev = cs_out;
            tick();
            if (cs_out !== prev) edges++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1;
        set_pins(2'b00, 2'b00, 1'b1);
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = '0;
        repeat (3) tick();
        check("reset_cs_out", int'(cs_out), 0);
        check("reset_cs_oe_n", int'(cs_oe_n), 1);
        rst = 1'b0;
        tick();

        // Red hp=10 at x5: N=50, first rise 53 after the pins.
        write_hp(2'd0, 16'd10);
        set_pins(2'b10, 2'b00, 1'b0);
        wait_change(200, n); check("first_rise_n50", n, 53);
        check("first_rise_level", int'(cs_out), 1);
        wait_change(200, n); check("high_phase_n50", n, 50);
        wait_change(200, n); check("low_phase_n50", n, 50);

        // Switch to green hp=4: N=20, counter restarts, level held.
        write_hp(2'd1, 16'd4);
        set_pins(2'b10, 2'b11, 1'b0);
        wait_change(200, n); check("filter_switch_edge", n, 23);
        wait_change(200, n); check("green_half", n, 20);

        // 2 % scaling with hp=3: half-period 150, then power-down.
        write_hp(2'd1, 16'd3);
        set_pins(2'b01, 2'b11, 1'b0);
        wait_change(400, n); check("scale2pct_first", n, 153);
        wait_change(400, n); check("scale2pct_half", n, 150);
        set_pins(2'b00, 2'b11, 1'b0);
        wait_change(10, n); check("power_down_latency", n, 3);
        count_edges(20, n); check("off_no_edges", n, 0);

        // Blue dark, then hp=2 at x1.
        set_pins(2'b11, 2'b01, 1'b0);
        repeat (5) tick();
        count_edges(1000, n); check("dark_no_edges", n, 0);
        write_hp(2'd2, 16'd2);
        wait_change(20, n); check("dark_exit_rise", n, 3);
        wait_change(20, n); check("dark_exit_half_a", n, 2);
        wait_change(20, n); check("dark_exit_half_b", n, 2);

        // Red hp 10 -> 20 mid half-period.
        set_pins(2'b11, 2'b00, 1'b0);
        repeat (4) tick();
        wait_level(1'b0, 50);
        wait_level(1'b1, 50);
        write_hp(2'd0, 16'd20);
        wait_change(50, n); check("write_current_half", n, 9);
        wait_change(50, n); check("write_next_half", n, 20);
        wait_change(50, n); check("write_later_half", n, 20);

        // OE high for 40 cycles starting at a rise; phase resumes.
        wait_level(1'b1, 50);
        set_pins(2'b11, 2'b00, 1'b1);
        repeat (3) tick();
        check("oe_gate_cs_out", int'(cs_out), 0);
        check("oe_gate_cs_oe_n", int'(cs_oe_n), 1);
        repeat (37) tick();
        set_pins(2'b11, 2'b00, 1'b0);
        wait_change(10, n); check("oe_resume_latency", n, 3);
        wait_change(50, n); check("oe_phase_kept", n, 17);

        // Asynchronous reset mid half-period.
        repeat (7) tick();
        rst = 1'b1;
        set_pins(2'b00, 2'b00, 1'b1);
        #1;
        check("async_reset_cs_out", int'(cs_out), 0);
        check("async_reset_cs_oe_n", int'(cs_oe_n), 1);
        repeat (2) tick();
        rst = 1'b0;
        count_edges(60, n); check("post_reset_quiet", n, 0);

        // Randomised traffic checked by the model.
        for (int it = 0; it < 150; it++) begin
            logic [1:0] sc, fl;
            logic       oe;
            if ($urandom_range(0, 2) == 0)
                write_hp(2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 0) begin
                sc = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                fl = 2'($urandom_range(0, 3));
                oe = ($urandom_range(0, 5) == 0);
                set_pins(sc, fl, oe);
            end
            repeat ($urandom_range(1, 60)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
